control_unit_v3: RTL
====================

// Module: control_unit_v3
// PURPOSE
//  Decode-stage control unit with a built-in multi-cycle lane sequencer.
//  It decodes Opcode/S/Func/Rd into the datapath control word and registers
//  that word into the execute stage (1-cycle latency).
//  Vector opcodes are replayed once per lane over LANES consecutive cycles.
//  The Stuck output stalls fetch/decode while lanes remain to be issued.
// PARAMETERS
//  LANES       4   elements per vector op (>=1); LANES=1 makes vector ops single-cycle
//  REG_ADDR_W  4   width of Rd
//  PC_REG      15  register index aliased to the PC
// PORTS
//  clk         in   1             clock, all state updates on rising edge
//  rst         in   1             asynchronous reset, active-high
//  Valid       in   1             decode-stage instruction valid
//  FlushE      in   1             squash the instruction entering execute
//  Opcode      in   3             instruction class
//  S           in   2             S[0]=set flags, S[1]=ALU select
//  Func        in   3             ALU function
//  Rd          in   REG_ADDR_W    destination register
//  PCSrc       out  1             PC written by this issue (reg)
//  RegWrite    out  1             register-file write enable (reg)
//  MemtoReg    out  1             writeback from memory (reg)
//  MemWrite    out  1             data memory write enable (reg)
//  ALUControl  out  3             ALU operation (reg)
//  ALUSel      out  1             ALU unit select (reg)
//  Branch      out  1             branch issue (reg)
//  ALUSrc      out  1             0=register operand, 1=immediate (reg)
//  FlagWrite   out  2             flag-update enables (reg)
//  ImmSrc      out  2             immediate format (reg)
//  RegSrc      out  2             register-read source mux (reg)
//  LaneIdx     out  $clog2(LANES) lane of current issue, 0 if LANES=1 (reg)
//  LaneLast    out  1             current issue is final lane / scalar (reg)
//  Stuck       out  1             combinational stall request to fetch/decode
// BEHAVIOUR
//  Decode table (Opcode: ALUSrc ImmSrc RegSrc RegW MemW MemtoReg Branch ALUControl):
//   000 DP-reg  0 00 00 1 0 0 0 Func
//   001 DP-imm  1 00 00 1 0 0 0 Func
//   010 LOAD    1 01 00 1 0 1 0 000(add)
//   011 STORE   1 01 10 0 1 0 0 000
//   100 BRANCH  1 10 01 0 0 0 1 000
//   101 VDP     0 00 00 1 0 0 0 Func
//   110 VLOAD   1 01 00 1 0 1 0 000
//   111 VSTORE  1 01 10 0 1 0 0 000
//  FlagWrite={S[0],S[0]} for 000/001/101, else 00. ALUSel=S[1] for all opcodes.
//  PCSrc=Branch | (RegWrite & Rd==PC_REG); for vector ops only on the LaneLast issue.
//  Issue gating: if !Valid or FlushE, the registered control word is all-zero
//   (LaneIdx=0, LaneLast=0).
//  FSM states: IDLE, SEQ; lane counter cnt.
//   IDLE: a valid vector op with !FlushE and LANES>1 issues lane 0 and latches
//    Opcode/S/Func/Rd, sets cnt=1, and goes to SEQ. Stuck=1 this cycle.
//    A scalar op or LANES=1 issues with LaneLast=1 and stays in IDLE.
//   SEQ: decode inputs and Valid are ignored. The latched copy issues with
//    LaneIdx=cnt. Stuck=(cnt<LANES-1).
//    If cnt==LANES-1: LaneLast=1, go to IDLE; else cnt++.
//  FlushE in SEQ: abort. Zero word issued, next state IDLE, Stuck=0 that cycle.
//  Reset (async, any state): IDLE, cnt=0, all registered outputs 0.
//   Stuck=0 while rst is high.
//  Vector op total occupancy = LANES cycles; Stuck high for LANES-1 of them.
// TESTING
//  1 rst high -> all outputs 0; release, Valid=1 Opcode=000 Func=010 S=01 Rd=3
//    -> next edge RegWrite=1 ALUControl=010 FlagWrite=11 LaneLast=1 Stuck=0
//  2 LANES=4, Opcode=101 Rd=2 -> Stuck 1,1,1,0 over 4 cycles;
//    LaneIdx 0,1,2,3 registered; LaneLast only at lane 3
//  3 Opcode=000 Rd=15 RegW -> PCSrc=1; Opcode=101 Rd=15 -> PCSrc=1 only at LaneIdx=3
//  4 VLOAD lane 1 with FlushE=1 -> zero word issued, Stuck=0, IDLE;
//    next scalar instruction issues normally
//  5 rst asserted mid-SEQ (cnt=2) -> outputs 0 immediately, Stuck=0;
//    after release, a scalar op issues
//  6 LANES=1, Opcode=111 -> single issue MemWrite=1 RegSrc=10 LaneLast=1, Stuck never 1

Source files
------------

// File: rtl/control_unit_v3.sv
// -----------------------------------------------------------------------------
// control_unit_v3
// Decode-stage control unit with a built-in multi-cycle lane sequencer.
// The instruction in decode (Opcode/S/Func/Rd) is decoded into the datapath
// control word and registered into the execute stage one cycle later.
// Vector opcodes (101 VDP, 110 VLOAD, 111 VSTORE) are replayed once per lane
// over LANES consecutive cycles; Stuck holds fetch/decode while lanes remain.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   Valid         decode-stage instruction valid
//   FlushE        squash the instruction entering execute
//   Opcode, S, Func, Rd   instruction fields
//   PCSrc .. RegSrc       registered execute-stage control word
//   LaneIdx       registered lane index of the current issue (0 if LANES=1)
//   LaneLast      registered: current issue is the final lane or a scalar
//   Stuck         combinational stall request to fetch/decode
//   dbg_state     sequencer state (0 = IDLE, 1 = SEQ) for observation
//
// Handshake: an instruction presented with Valid=1 while Stuck=0 is consumed
// on the next rising edge. While Stuck=1 the decode stage must hold; the
// sequencer ignores Valid and the decode fields until Stuck drops.
// -----------------------------------------------------------------------------
module control_unit_v3 #(
  parameter int LANES      = 4,
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15,
  localparam int LIDX_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid,
  input  logic                  FlushE,
  input  logic [2:0]            Opcode,
  input  logic [1:0]            S,
  input  logic [2:0]            Func,
  input  logic [REG_ADDR_W-1:0] Rd,
  output logic                  PCSrc,
  output logic                  RegWrite,
  output logic                  MemtoReg,
  output logic                  MemWrite,
  output logic [2:0]            ALUControl,
  output logic                  ALUSel,
  output logic                  Branch,
  output logic                  ALUSrc,
  output logic [1:0]            FlagWrite,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [LIDX_W-1:0]     LaneIdx,
  output logic                  LaneLast,
  output logic                  Stuck,
  output logic                  dbg_state
);

  localparam bit                    MULTI     = (LANES > 1);
  localparam logic [LIDX_W-1:0]     LAST_LANE = LIDX_W'(LANES - 1);
  localparam logic [REG_ADDR_W-1:0] PC_ADDR   = REG_ADDR_W'(PC_REG);

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [2:0] alucontrol;
    logic       alusel;
    logic       branch;
    logic       alusrc;
    logic [1:0] flagwrite;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
  } ctrl_t;

  // Decode one issue. 'last' qualifies PCSrc so that a vector op writing the
  // PC only redirects fetch on its final lane; scalars always pass last=1.
  function automatic ctrl_t decode(input logic [2:0]            op,
                                   input logic [1:0]            s,
                                   input logic [2:0]            func,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic                  last);
    ctrl_t c;
    c        = '0;
    c.alusel = s[1];
    case (op)
      3'b000, 3'b101: begin            // DP-reg / VDP
        c.regwrite   = 1'b1;
        c.alucontrol = func;
        c.flagwrite  = {2{s[0]}};
      end
      3'b001: begin                    // DP-imm
        c.alusrc     = 1'b1;
        c.regwrite   = 1'b1;
        c.alucontrol = func;
        c.flagwrite  = {2{s[0]}};
      end
      3'b010, 3'b110: begin            // LOAD / VLOAD
        c.alusrc   = 1'b1;
        c.immsrc   = 2'b01;
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      3'b011, 3'b111: begin            // STORE / VSTORE
        c.alusrc   = 1'b1;
        c.immsrc   = 2'b01;
        c.regsrc   = 2'b10;
        c.memwrite = 1'b1;
      end
      3'b100: begin                    // BRANCH
        c.alusrc = 1'b1;
        c.immsrc = 2'b10;
        c.regsrc = 2'b01;
        c.branch = 1'b1;
      end
      default: c = '0;
    endcase
    c.pcsrc = (c.branch | (c.regwrite & (rd == PC_ADDR))) & last;
    return c;
  endfunction

  function automatic logic is_vec(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110) || (op == 3'b111);
  endfunction

  state_t                  state;
  logic [LIDX_W-1:0]       cnt;
  logic [2:0]              lat_op;
  logic [1:0]              lat_s;
  logic [2:0]              lat_func;
  logic [REG_ADDR_W-1:0]   lat_rd;
  ctrl_t                   ex_q;
  logic [LIDX_W-1:0]       lane_q;
  logic                    last_q;

  logic                    seq_last;
  assign seq_last = (cnt == LAST_LANE);

  // Sequencer and execute-stage control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_op   <= '0;
      lat_s    <= '0;
      lat_func <= '0;
      lat_rd   <= '0;
      ex_q     <= '0;
      lane_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lane_q <= '0;
          if (Valid && !FlushE) begin
            if (MULTI && is_vec(Opcode)) begin
              // Lane 0 issues now; the copy replays the remaining lanes.
              ex_q     <= decode(Opcode, S, Func, Rd, 1'b0);
              last_q   <= 1'b0;
              lat_op   <= Opcode;
              lat_s    <= S;
              lat_func <= Func;
              lat_rd   <= Rd;
              cnt      <= LIDX_W'(1);
              state    <= SEQ;
            end else begin
              ex_q   <= decode(Opcode, S, Func, Rd, 1'b1);
              last_q <= 1'b1;
            end
          end else begin
            ex_q   <= '0;
            last_q <= 1'b0;
          end
        end
        SEQ: begin
          if (FlushE) begin
            // Abort the remaining lanes; nothing reaches execute.
            ex_q   <= '0;
            lane_q <= '0;
            last_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            ex_q   <= decode(lat_op, lat_s, lat_func, lat_rd, seq_last);
            lane_q <= cnt;
            last_q <= seq_last;
            if (seq_last) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + LIDX_W'(1);
            end
          end
        end
        default: begin
          ex_q   <= '0;
          lane_q <= '0;
          last_q <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Stall while lanes beyond the one issuing this cycle are still pending.
  always_comb begin
    Stuck = 1'b0;
    if (rst) begin
      Stuck = 1'b0;
    end else if (state == IDLE) begin
      Stuck = MULTI && Valid && !FlushE && is_vec(Opcode);
    end else begin
      Stuck = !FlushE && (cnt < LAST_LANE);
    end
  end

  assign PCSrc      = ex_q.pcsrc;
  assign RegWrite   = ex_q.regwrite;
  assign MemtoReg   = ex_q.memtoreg;
  assign MemWrite   = ex_q.memwrite;
  assign ALUControl = ex_q.alucontrol;
  assign ALUSel     = ex_q.alusel;
  assign Branch     = ex_q.branch;
  assign ALUSrc     = ex_q.alusrc;
  assign FlagWrite  = ex_q.flagwrite;
  assign ImmSrc     = ex_q.immsrc;
  assign RegSrc     = ex_q.regsrc;
  assign LaneIdx    = lane_q;
  assign LaneLast   = last_q;
  assign dbg_state  = (state == SEQ);

endmodule
